// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared types and constants for the SoC reset sequencer
package reset_seq_pkg;

  typedef enum logic [1:0] {PLL_WAIT, POR_HOLD, SYS_HOLD, RUN} state_t;
  typedef enum logic [1:0] {CAUSE_POR, CAUSE_PLL, CAUSE_BTN, CAUSE_SYS} rst_cause_t;

  localparam int RST_CNT_W = 8;

  function automatic logic [RST_CNT_W-1:0] sat_inc(input logic [RST_CNT_W-1:0] v);
    return (&v) ? v : v + RST_CNT_W'(1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser and debounce filter for the reset pushbutton
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic IN,
  output logic OUT
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          in_m;
  logic          in_s;
  logic [DW-1:0] cnt;

  // OUT only follows the synchronised input after DEBOUNCE_CYCLES consecutive disagreeing cycles
  always_ff @(posedge CLK) begin
    if (RESET) begin
      in_m <= 1'b0;
      in_s <= 1'b0;
      cnt  <= '0;
      OUT  <= 1'b0;
    end else begin
      in_m <= IN;
      in_s <= in_m;
      if (in_s == OUT) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        OUT <= in_s;
        cnt <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/reset_seq_ctrl.sv
// rtl/reset_seq_ctrl.sv - ordered PORESETn/HRESETn release with reset-cause and warm-reset count
module reset_seq_ctrl
  import reset_seq_pkg::*;
#(
  parameter int POR_CYCLES      = 255,
  parameter int SYS_CYCLES      = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 PLL_LOCKED,
  input  logic                 BTN_RESET,
  input  logic                 SYSRESETREQ,
  output logic                 PORESETn,
  output logic                 HRESETn,
  output logic [1:0]           RST_CAUSE,
  output logic [RST_CNT_W-1:0] RST_CNT
);

  localparam int HOLD_MAX = (POR_CYCLES > SYS_CYCLES) ? POR_CYCLES : SYS_CYCLES;
  localparam int HW       = $clog2(HOLD_MAX) + 1;

  state_t        state;
  state_t        state_nxt;
  logic [HW-1:0] ctr;
  logic [HW-1:0] ctr_nxt;
  logic [1:0]    cause_nxt;
  logic          exit_run;
  logic          pll_m;
  logic          pll_s;
  logic          btn_db;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .CLK  (CLK),
    .RESET(RESET),
    .IN   (BTN_RESET),
    .OUT  (btn_db)
  );

  always_comb begin
    state_nxt = state;
    ctr_nxt   = ctr;
    cause_nxt = RST_CAUSE;
    exit_run  = 1'b0;
    case (state)
      PLL_WAIT: begin
        if (pll_s && !btn_db) begin
          state_nxt = POR_HOLD;
          ctr_nxt   = HW'(POR_CYCLES - 1);
        end
      end
      POR_HOLD: begin
        if (!pll_s || btn_db) begin
          state_nxt = PLL_WAIT;
        end else if (ctr == '0) begin
          state_nxt = SYS_HOLD;
          ctr_nxt   = HW'(SYS_CYCLES - 1);
        end else begin
          ctr_nxt = ctr - HW'(1);
        end
      end
      SYS_HOLD: begin
        if (!pll_s || btn_db) begin
          state_nxt = PLL_WAIT;
        end else if (ctr == '0) begin
          state_nxt = RUN;
        end else begin
          ctr_nxt = ctr - HW'(1);
        end
      end
      RUN: begin
        // PLL loss outranks the button, which outranks the core's warm request
        if (!pll_s) begin
          state_nxt = PLL_WAIT;
          cause_nxt = CAUSE_PLL;
          exit_run  = 1'b1;
        end else if (btn_db) begin
          state_nxt = PLL_WAIT;
          cause_nxt = CAUSE_BTN;
          exit_run  = 1'b1;
        end else if (SYSRESETREQ) begin
          state_nxt = SYS_HOLD;
          ctr_nxt   = HW'(SYS_CYCLES - 1);
          cause_nxt = CAUSE_SYS;
          exit_run  = 1'b1;
        end
      end
      default: state_nxt = PLL_WAIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= PLL_WAIT;
      ctr       <= '0;
      pll_m     <= 1'b0;
      pll_s     <= 1'b0;
      PORESETn  <= 1'b0;
      HRESETn   <= 1'b0;
      RST_CAUSE <= CAUSE_POR;
      RST_CNT   <= '0;
    end else begin
      pll_m     <= PLL_LOCKED;
      pll_s     <= pll_m;
      state     <= state_nxt;
      ctr       <= ctr_nxt;
      PORESETn  <= (state_nxt == SYS_HOLD) || (state_nxt == RUN);
      HRESETn   <= (state_nxt == RUN);
      RST_CAUSE <= cause_nxt;
      if (exit_run) begin
        RST_CNT <= sat_inc(RST_CNT);
      end
    end
  end

endmodule
